// File: rtl/latency_scheduler.sv
// -----------------------------------------------------------------------------
// latency_scheduler
//
// Purpose:
//   Several requesters share one external datapath. The datapath has a fixed
//   latency and cannot stall. A round-robin arbiter grants one issue slot per
//   cycle. Each issued op carries its requester ID down a tag pipeline that
//   runs alongside the datapath. When an op reaches the end of the tag
//   pipeline, its result is written into a tagged output FIFO. Because the
//   datapath cannot stall, an op is issued only when a FIFO slot is
//   guaranteed to be free when that op retires.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      per-requester op valid                      [NREQ]
//   req_data       per-requester operand, lane i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot grant; an op transfers on valid & ready
//   pipe_in_data   operand sent to the datapath input (zero when no grant)
//   pipe_out_data  datapath output, LATENCY cycles after pipe_in_data
//   out_valid      FIFO head is valid
//   out_data       FIFO head result (zero when empty)
//   out_id         requester ID of the FIFO head (zero when empty)
//   out_ready      consumer accepts the FIFO head
//   in_flight      number of ops currently inside the datapath
//   busy           ops are in flight or the FIFO is non-empty
// -----------------------------------------------------------------------------
module latency_scheduler #(
  parameter int LATENCY    = 5,
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ*WIDTH-1:0]           req_data,
  output logic [NREQ-1:0]                 req_ready,
  output logic [WIDTH-1:0]                pipe_in_data,
  input  logic [WIDTH-1:0]                pipe_out_data,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  output logic [$clog2(NREQ)-1:0]         out_id,
  input  logic                            out_ready,
  output logic [$clog2(LATENCY+1)-1:0]    in_flight,
  output logic                            busy
);

  localparam int          IDW     = $clog2(NREQ);
  localparam int          IFW     = $clog2(LATENCY + 1);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NREQ_U  = NREQ;
  localparam int unsigned LAT_U   = LATENCY;
  localparam int unsigned DEPTH_U = FIFO_DEPTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]   tag_id_q [LATENCY];
  logic [IDW-1:0]   tag_id_d [LATENCY];
  logic [PW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]    count_q,     count_d;
  logic [IFW-1:0]   in_flight_q, in_flight_d;

  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [IDW-1:0]   id_mem   [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------------
  logic           credit_ok;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           xfer;
  logic           retire;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so that non-power-of-two depths work.
    if (p == PW'(DEPTH_U - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Credit uses only registered state. Every op in the datapath already
  // owns a FIFO slot. A pop in this cycle frees its slot only from the
  // next cycle on.
  always_comb begin
    credit_ok = (32'(in_flight_q) + 32'(count_q)) < DEPTH_U;
  end

  // Round-robin search starts one position above the last granted index.
  // Grants are forced low while reset is asserted, so req_ready stays at
  // zero throughout reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (credit_ok && rst_n) begin
      for (int unsigned off = 1; off <= NREQ_U; off++) begin
        cand = IDW'((32'(rr_ptr_q) + off) % NREQ_U);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready    = grant_vld ? (NREQ'(1) << grant_idx) : '0;
    pipe_in_data = grant_vld ? req_data[grant_idx*WIDTH +: WIDTH] : '0;
  end

  // A grant is given only to a valid requester, so every grant is a transfer.
  assign xfer   = grant_vld;
  assign retire = tag_vld_q[LATENCY-1];
  assign push   = retire;
  assign pop    = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = xfer ? grant_idx : rr_ptr_q;

    // The tag chain shifts every cycle. It mirrors the datapath, which can
    // never be stalled.
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = xfer;
    tag_id_d[0]  = xfer ? grant_idx : '0;
    for (int unsigned i = 1; i < LAT_U; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    in_flight_d = in_flight_q;
    if (xfer && !retire) begin
      in_flight_d = in_flight_q + IFW'(1);
    end else if (!xfer && retire) begin
      in_flight_d = in_flight_q - IFW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= IDW'(NREQ_U - 1);
      tag_vld_q   <= '0;
      for (int unsigned i = 0; i < LAT_U; i++) begin
        tag_id_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
    end
  end

  // FIFO storage is not reset. The count and the pointers decide which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= pipe_out_data;
      id_mem[wr_ptr_q]   <= tag_id_q[LATENCY-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? data_mem[rd_ptr_q] : '0;
    out_id    = out_valid ? id_mem[rd_ptr_q]   : '0;
    in_flight = in_flight_q;
    busy      = (in_flight_q != '0) || out_valid;
  end

  // Credit accounting guarantees that a retiring op always finds a free slot.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) push |-> (count_q < CW'(DEPTH_U))
  );

endmodule

// File: tb/tb_latency_scheduler.sv
module tb_latency_scheduler;

  localparam int LAT = 5;
  localparam int W   = 8;
  localparam int N   = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           out_ready;

  // Instance with FIFO_DEPTH = 8
  logic [N-1:0] rdy1;
  logic [W-1:0] pin1, pout1, od1;
  logic         ov1, busy1;
  logic [1:0]   oid1;
  logic [2:0]   inf1;

  // Instance with FIFO_DEPTH = 3
  logic [N-1:0] rdy3;
  logic [W-1:0] pin3, pout3, od3;
  logic         ov3, busy3;
  logic [1:0]   oid3;
  logic [2:0]   inf3;

  int checks = 0;
  int errors = 0;

  latency_scheduler #(.LATENCY(LAT), .WIDTH(W), .NREQ(N), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .pipe_in_data(pin1), .pipe_out_data(pout1),
    .out_valid(ov1), .out_data(od1), .out_id(oid1), .out_ready(out_ready),
    .in_flight(inf1), .busy(busy1)
  );

  latency_scheduler #(.LATENCY(LAT), .WIDTH(W), .NREQ(N), .FIFO_DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy3), .pipe_in_data(pin3), .pipe_out_data(pout3),
    .out_valid(ov3), .out_data(od3), .out_id(oid3), .out_ready(out_ready),
    .in_flight(inf3), .busy(busy3)
  );

  // Identity datapaths: plain LAT-stage delay lines that are never reset
  logic [W-1:0] dp1 [LAT];
  logic [W-1:0] dp3 [LAT];
  always @(posedge clk) begin
    dp1[0] <= pin1;
    dp3[0] <= pin3;
    for (int i = 1; i < LAT; i++) begin
      dp1[i] <= dp1[i-1];
      dp3[i] <= dp3[i-1];
    end
  end
  assign pout1 = dp1[LAT-1];
  assign pout3 = dp3[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: the ops in the system, listed in issue order. Each op
  // holds its cycle of visibility (issue cycle + LAT + 1). Ops in the
  // system are in flight or waiting in the FIFO. An op counts as in flight
  // until its visibility cycle. Credit is the number of ops in the system
  // compared with the depth.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          id;
    logic [W-1:0] data;
    int          rdy;
  } op_t;

  op_t          mq[$];
  int           cyc     = 0;
  int           last_g  = N - 1;
  int           m_depth = 8;
  int           m_g;
  logic [N-1:0] m_ready;
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [1:0]   m_oid;
  int           m_inf;
  logic         m_busy;

  function automatic void model_eval();
    m_ready = '0; m_ov = 1'b0; m_od = '0; m_oid = '0; m_inf = 0; m_busy = 1'b0; m_g = -1;
    if (rst_n !== 1'b1) return;
    foreach (mq[i]) if (mq[i].rdy > cyc) m_inf++;
    m_busy = (mq.size() != 0);
    if (mq.size() != 0 && mq[0].rdy <= cyc) begin
      m_ov  = 1'b1;
      m_od  = mq[0].data;
      m_oid = 2'(mq[0].id);
    end
    if (mq.size() < m_depth) begin
      for (int k = 1; k <= N; k++) begin
        if (m_g < 0 && req_valid[(last_g + k) % N]) m_g = (last_g + k) % N;
      end
    end
    if (m_g >= 0) m_ready[m_g] = 1'b1;
  endfunction

  function automatic void model_step();
    op_t o;
    if (rst_n !== 1'b1) begin
      mq.delete();
      last_g = N - 1;
      cyc++;
      return;
    end
    if (m_ov && out_ready) void'(mq.pop_front());
    if (m_g >= 0) begin
      o.id   = m_g;
      o.data = req_data[m_g*W +: W];
      o.rdy  = cyc + LAT + 1;
      mq.push_back(o);
      last_g = m_g;
    end
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    last_g = N - 1;
    cyc    = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = 32'hDEADBEEF;
    out_ready = 1'b1;
    #1;
    checks++; if (rdy1 !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", rdy1); end
    checks++; if (ov1 !== 1'b0)     begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov1); end
    checks++; if (od1 !== 8'h00)    begin errors++; $display("FAIL reset_out_data got=%h exp=00", od1); end
    checks++; if (oid1 !== 2'd0)    begin errors++; $display("FAIL reset_out_id got=%0d exp=0", oid1); end
    checks++; if (inf1 !== 3'd0)    begin errors++; $display("FAIL reset_in_flight got=%0d exp=0", inf1); end
    checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (rdy3 !== 4'b0000) begin errors++; $display("FAIL reset_ready_d3 got=%b exp=0000", rdy3); end
    apply_reset();
  endtask

  task automatic test_single_op();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = (i == 0) ? 4'b0100 : 4'b0000;
      req_data  = 32'h005A_0000;
      out_ready = 1'b1;
      #1; model_eval();
      checks++; if (rdy1 !== ((i == 0) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_ready i=%0d got=%b", i, rdy1); end
      checks++; if (ov1 !== (i == 6)) begin errors++; $display("FAIL single_out_valid i=%0d got=%b exp=%b", i, ov1, (i == 6)); end
      if (i == 6) begin
        checks++; if ({oid1, od1} !== {2'd2, 8'h5A}) begin errors++; $display("FAIL single_result got id=%0d data=%h exp id=2 data=5a", oid1, od1); end
      end
      checks++; if (inf1 !== ((i >= 1 && i <= 5) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL single_in_flight i=%0d got=%0d", i, inf1); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      req_data  = 32'h1312_1110;
      out_ready = 1'b1;
      #1; model_eval();
      checks++; if (rdy1 !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, rdy1, 4'b0001 << (i % 4)); end
      checks++; if (ov1 !== (i >= 6)) begin errors++; $display("FAIL rr_out_valid i=%0d got=%b", i, ov1); end
      if (i >= 6) begin
        checks++;
        if (oid1 !== 2'((i - 6) % 4) || od1 !== 8'(8'h10 + (i - 6) % 4)) begin
          errors++; $display("FAIL rr_result i=%0d got id=%0d data=%h exp id=%0d", i, oid1, od1, (i - 6) % 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int xfers;
    xfers = 0;
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      req_data  = $urandom;
      out_ready = (i >= 20);
      #1; model_eval();
      if (i < 20 && rdy1 !== 4'b0000) xfers++;
      checks++; if (rdy1 !== m_ready) begin errors++; $display("FAIL bp_grant i=%0d got=%b exp=%b", i, rdy1, m_ready); end
      checks++; if (ov1 !== m_ov) begin errors++; $display("FAIL bp_out_valid i=%0d got=%b exp=%b", i, ov1, m_ov); end
      if (m_ov) begin
        checks++; if ({oid1, od1} !== {m_oid, m_od}) begin errors++; $display("FAIL bp_result i=%0d got %0d/%h exp %0d/%h", i, oid1, od1, m_oid, m_od); end
      end
      checks++; if (inf1 !== 3'(m_inf)) begin errors++; $display("FAIL bp_in_flight i=%0d got=%0d exp=%0d", i, inf1, m_inf); end
      if (i == 20) begin
        checks++; if (rdy1 !== 4'b0000) begin errors++; $display("FAIL bp_first_pop_no_issue got=%b exp=0000", rdy1); end
      end
      if (i == 21) begin
        checks++; if (rdy1 !== 4'b0001) begin errors++; $display("FAIL bp_resume got=%b exp=0001", rdy1); end
      end
      tick();
    end
    checks++; if (xfers != 8) begin errors++; $display("FAIL bp_total_transfers got=%0d exp=8", xfers); end
  endtask

  task automatic test_starvation();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = 4'b1001;
      req_data  = $urandom;
      out_ready = 1'b1;
      #1; model_eval();
      checks++; if (rdy1 !== ((i % 2 == 0) ? 4'b0001 : 4'b1000)) begin errors++; $display("FAIL starve_grant i=%0d got=%b", i, rdy1); end
      checks++; if (ov1 !== m_ov) begin errors++; $display("FAIL starve_out_valid i=%0d got=%b exp=%b", i, ov1, m_ov); end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1; model_eval();
      checks++; if (rdy1 !== m_ready) begin errors++; $display("FAIL rand_grant i=%0d got=%b exp=%b", i, rdy1, m_ready); end
      checks++; if (pin1 !== ((m_g >= 0) ? req_data[m_g*W +: W] : 8'h00)) begin errors++; $display("FAIL rand_pipe_in i=%0d got=%h", i, pin1); end
      checks++; if (ov1 !== m_ov) begin errors++; $display("FAIL rand_out_valid i=%0d got=%b exp=%b", i, ov1, m_ov); end
      if (m_ov) begin
        checks++; if ({oid1, od1} !== {m_oid, m_od}) begin errors++; $display("FAIL rand_result i=%0d got %0d/%h exp %0d/%h", i, oid1, od1, m_oid, m_od); end
      end
      checks++; if (inf1 !== 3'(m_inf)) begin errors++; $display("FAIL rand_in_flight i=%0d got=%0d exp=%0d", i, inf1, m_inf); end
      checks++; if (busy1 !== m_busy) begin errors++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy1, m_busy); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst_n     = (i != 5);
      req_valid = (i < 3) ? 4'b0010 : ((i == 16) ? 4'b1000 : 4'b0000);
      req_data  = $urandom;
      out_ready = 1'b1;
      #1; model_eval();
      checks++; if (rdy1 !== m_ready) begin errors++; $display("FAIL mid_grant i=%0d got=%b exp=%b", i, rdy1, m_ready); end
      checks++; if (ov1 !== m_ov) begin errors++; $display("FAIL mid_out_valid i=%0d got=%b exp=%b", i, ov1, m_ov); end
      checks++; if (inf1 !== 3'(m_inf)) begin errors++; $display("FAIL mid_in_flight i=%0d got=%0d exp=%0d", i, inf1, m_inf); end
      checks++; if (busy1 !== m_busy) begin errors++; $display("FAIL mid_busy i=%0d got=%b exp=%b", i, busy1, m_busy); end
      if (i == 5) begin
        checks++; if ({oid1, od1} !== 10'd0) begin errors++; $display("FAIL mid_reset_outputs got %0d/%h exp 0/00", oid1, od1); end
      end
      if (i >= 6 && i <= 15) begin
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL mid_spurious_valid i=%0d got=%b exp=0", i, ov1); end
      end
      if (i == 22) begin
        checks++; if (ov1 !== 1'b1 || oid1 !== 2'd3 || od1 !== m_od) begin errors++; $display("FAIL mid_after_reset_op got v=%b id=%0d data=%h exp v=1 id=3 data=%h", ov1, oid1, od1, m_od); end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fifo_depth3();
    int win[$];
    int sum;
    m_depth = 3;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = (i < 360) ? 4'b1111 : 4'b0000;
      req_data  = $urandom;
      out_ready = (i >= 360) || ($urandom_range(0, 9) < 7);
      #1; model_eval();
      checks++; if (rdy3 !== m_ready) begin errors++; $display("FAIL d3_grant i=%0d got=%b exp=%b", i, rdy3, m_ready); end
      checks++; if (ov3 !== m_ov) begin errors++; $display("FAIL d3_out_valid i=%0d got=%b exp=%b", i, ov3, m_ov); end
      if (m_ov) begin
        checks++; if ({oid3, od3} !== {m_oid, m_od}) begin errors++; $display("FAIL d3_result i=%0d got %0d/%h exp %0d/%h", i, oid3, od3, m_oid, m_od); end
      end
      checks++; if (inf3 !== 3'(m_inf)) begin errors++; $display("FAIL d3_in_flight i=%0d got=%0d exp=%0d", i, inf3, m_inf); end
      checks++; if (busy3 !== m_busy) begin errors++; $display("FAIL d3_busy i=%0d got=%b exp=%b", i, busy3, m_busy); end
      win.push_back((rdy3 != 4'b0000) ? 1 : 0);
      if (win.size() > LAT + 1) void'(win.pop_front());
      sum = 0;
      foreach (win[k]) sum += win[k];
      checks++; if (sum > 3) begin errors++; $display("FAIL d3_window_issues i=%0d got=%0d exp<=3", i, sum); end
      tick();
    end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL d3_drained got busy=%b exp=0", busy3); end
    m_depth = 8;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_starvation();
    test_random();
    test_reset_midflight();
    test_fifo_depth3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
